tweakey_bank: RTL and testbench

//  Multi-lane tweakey state register for the SKINNY-based Romulus cores; successor to the single-word key register.

---
 rtl/tweakey_bank_pkg.sv | 34 +++
 rtl/tweakey_lane.sv | 40 ++++
 rtl/tweakey_bank.sv | 109 ++++++++++
 tb/tb_tweakey_bank.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tweakey_bank_pkg.sv
// Shared types, Romulus-N default sizes and width helpers for the tweakey bank.
package tweakey_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tk_state_e;

  localparam int unsigned RN_WIDTH  = 32;
  localparam int unsigned RN_WORDS  = 4;
  localparam int unsigned RN_LANES  = 3;
  localparam int unsigned RN_ROUNDS = 40;

  // Never returns 0 so a one-entry range still gets a real 1-bit port.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(n)) r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned lane_w(input int unsigned words, input int unsigned width);
    return words * width;
  endfunction

  function automatic int unsigned state_w(input int unsigned lanes, input int unsigned words,
                                          input int unsigned width);
    return lanes * words * width;
  endfunction

endpackage

// File: rtl/tweakey_lane.sv
// One tweakey lane: working register plus shadow copy.
// Strobes arrive pre-qualified by the top; restore beats update, update beats load.
module tweakey_lane
  import tweakey_bank_pkg::*;
#(
  parameter int unsigned WIDTH      = RN_WIDTH,
  parameter int unsigned WORDS      = RN_WORDS,
  parameter logic        INIT_VALUE = 1'b0,
  localparam int unsigned LW        = lane_w(WORDS, WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             update,
  input  logic [LW-1:0]    next,
  input  logic             save,
  input  logic             restore,
  output logic [LW-1:0]    state
);

  logic [LW-1:0] shadow;
  logic [LW-1:0] shifted;

  // Shift up by one word so the first beat ends in the MSBs after WORDS beats.
  assign shifted = (state << WIDTH) | LW'(ld_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= {LW{INIT_VALUE}};
      shadow <= {LW{INIT_VALUE}};
    end else begin
      if (restore)     state <= shadow;
      else if (update) state <= next;
      else if (load)   state <= shifted;
      if (save)        shadow <= state;
    end
  end

endmodule

// File: rtl/tweakey_bank.sv
// Multi-lane tweakey register: word-serial load, round-by-round update, save/restore.
// FSM IDLE -> RUN (ROUNDS updates) -> DONE (one-cycle pulse) -> IDLE; en=0 freezes everything.
module tweakey_bank
  import tweakey_bank_pkg::*;
#(
  parameter int unsigned WIDTH      = RN_WIDTH,
  parameter int unsigned WORDS      = RN_WORDS,
  parameter int unsigned LANES      = RN_LANES,
  parameter int unsigned ROUNDS     = RN_ROUNDS,
  parameter logic        INIT_VALUE = 1'b0,
  localparam int unsigned LW        = lane_w(WORDS, WIDTH),
  localparam int unsigned SW        = state_w(LANES, WORDS, WIDTH),
  localparam int unsigned LANE_BITS = clog2(LANES),
  localparam int unsigned RND_BITS  = clog2(ROUNDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [LANE_BITS-1:0] ld_lane,
  input  logic [WIDTH-1:0]     ld_data,
  input  logic                 start,
  input  logic                 save,
  input  logic                 restore,
  input  logic [SW-1:0]        ts_next,
  output logic [SW-1:0]        ts_state,
  output logic [RND_BITS-1:0]  round,
  output logic                 busy,
  output logic                 done
);

  tk_state_e           state_q, state_d;
  logic [RND_BITS-1:0] round_q, round_d;
  logic                busy_q, done_q;
  logic                idle, beat, do_restore, do_save, do_update, last;

  assign idle       = (state_q == ST_IDLE);
  assign ld_ready   = en & idle & ~restore & ~start;
  assign beat       = ld_valid & ld_ready;
  assign do_restore = en & idle & restore;
  assign do_save    = en & idle & save & ~restore & ~start;
  assign do_update  = en & (state_q == ST_RUN);
  assign last       = (round_q == RND_BITS'(ROUNDS - 1));

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !restore) begin
          state_d = ST_RUN;
          round_d = '0;
        end
      end
      ST_RUN: begin
        if (last) begin
          state_d = ST_DONE;
          round_d = '0;
        end else begin
          round_d = round_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        round_d = '0;
      end
    endcase
  end

  // busy/done are registered copies of the next state so outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      round_q <= round_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign round = round_q;
  assign busy  = busy_q;
  assign done  = done_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    tweakey_lane #(
      .WIDTH      (WIDTH),
      .WORDS      (WORDS),
      .INIT_VALUE (INIT_VALUE)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .load    (beat && (ld_lane == LANE_BITS'(l))),
      .ld_data (ld_data),
      .update  (do_update),
      .next    (ts_next[l*LW +: LW]),
      .save    (do_save),
      .restore (do_restore),
      .state   (ts_state[l*LW +: LW])
    );
  end

endmodule

// File: tb/tb_tweakey_bank.sv
// Scoreboarded bench for tweakey_bank with Romulus-N default sizes.
module tb_tweakey_bank;

  localparam int WIDTH = 32, WORDS = 4, LANES = 3, ROUNDS = 40;
  localparam int LW = WIDTH * WORDS, SW = LW * LANES;

  logic             clk = 1'b0;
  logic             rst, en, ld_valid, ld_ready, start, save, restore, busy, done;
  logic [1:0]       ld_lane;
  logic [WIDTH-1:0] ld_data;
  logic [SW-1:0]    ts_next, ts_state;
  logic [5:0]       round;

  int            checks = 0;
  int            errors = 0;
  int            mode   = 0;
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] model, pre;

  tweakey_bank dut (
    .clk(clk), .rst(rst), .en(en), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_lane(ld_lane), .ld_data(ld_data), .start(start), .save(save), .restore(restore),
    .ts_next(ts_next), .ts_state(ts_state), .round(round), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] inc_lanes(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*LW +: LW] = s[l*LW +: LW] + 1'b1;
    return r;
  endfunction

  function automatic logic [SW-1:0] shift_in(input logic [SW-1:0] s, input int lane,
                                             input logic [WIDTH-1:0] d);
    logic [SW-1:0] r;
    logic [LW-1:0] v;
    r = s;
    v = s[lane*LW +: LW];
    r[lane*LW +: LW] = {v[LW-WIDTH-1:0], d};
    return r;
  endfunction

  // External key-schedule model: bitwise invert, or +1 per lane.
  always_comb ts_next = (mode == 0) ? ~ts_state : inc_lanes(ts_state);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    ld_valid = 0; ld_lane = 0; ld_data = 0; start = 0; save = 0; restore = 0; en = 1;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    model = '0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (round !== 6'd0) begin errors++; $display("FAIL reset_round got %0d want 0", round); end
    checks++; if (ts_state !== '0) begin errors++; $display("FAIL reset_state got %h want 0", ts_state); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ld_ready); end
  endtask

  task automatic test_load;
    logic [WIDTH-1:0] w[4];
    logic [SW-1:0] e;
    w[0] = 32'h00010203; w[1] = 32'h04050607; w[2] = 32'h08090A0B; w[3] = 32'h0C0D0E0F;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_lane = 2'd0; ld_data = w[i];
      #1;
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL load_ready beat %0d got %b want 1", i, ld_ready); end
      model = shift_in(model, 0, w[i]);
      exp_q.push_back(model);
      tick();
      e = exp_q.pop_front();
      checks++; if (ts_state !== e) begin errors++; $display("FAIL load_beat %0d got %h want %h", i, ts_state, e); end
    end
    ld_valid = 0;
    checks++;
    if (ts_state !== {256'h0, 128'h000102030405060708090A0B0C0D0E0F}) begin
      errors++; $display("FAIL load_final got %h want lane0=000102..0F", ts_state);
    end
  endtask

  task automatic test_run;
    logic [SW-1:0] loaded, e;
    mode = 0;
    loaded = model;
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < ROUNDS; i++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_busy i=%0d got %b want 1", i, busy); end
      checks++; if (round !== 6'(i)) begin errors++; $display("FAIL run_round got %0d want %0d", round, i); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL run_done_early i=%0d got %b want 0", i, done); end
      exp_q.push_back(model);
      e = exp_q.pop_front();
      checks++; if (ts_state !== e) begin errors++; $display("FAIL run_state i=%0d got %h want %h", i, ts_state, e); end
      model = ~model;
      tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL run_done got %b want 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run_busy_end got %b want 0", busy); end
    checks++; if (round !== 6'd0) begin errors++; $display("FAIL run_round_end got %0d want 0", round); end
    checks++; if (ts_state !== loaded) begin errors++; $display("FAIL run_final got %h want %h", ts_state, loaded); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL run_done_width got %b want 0", done); end
  endtask

  task automatic test_enable_stall;
    logic [SW-1:0] snap;
    int n;
    mode = 0;
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 17; i++) tick();
    snap = ts_state;
    checks++; if (round !== 6'd17) begin errors++; $display("FAIL stall_round_pre got %0d want 17", round); end
    en = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (round !== 6'd17) begin errors++; $display("FAIL stall_round got %0d want 17", round); end
      checks++; if (ts_state !== snap) begin errors++; $display("FAIL stall_state got %h want %h", ts_state, snap); end
    end
    en = 1;
    n = 0;
    while (done !== 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (22 + n !== ROUNDS + 5) begin errors++; $display("FAIL stall_latency got %0d want %0d", 22 + n, ROUNDS + 5); end
    checks++; if (ts_state !== ~snap) begin errors++; $display("FAIL stall_final got %h want %h", ts_state, ~snap); end
    tick();
  endtask

  task automatic test_save_restore;
    logic [SW-1:0] e;
    int n;
    mode = 1;
    pre = ts_state;
    save = 1;
    tick();
    save = 0;
    start = 1;
    tick();
    start = 0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin tick(); n++; end
    e = pre;
    for (int i = 0; i < ROUNDS; i++) e = inc_lanes(e);
    checks++; if (ts_state !== e) begin errors++; $display("FAIL sr_run got %h want %h", ts_state, e); end
    tick();
    restore = 1;
    tick();
    restore = 0;
    checks++; if (ts_state !== pre) begin errors++; $display("FAIL sr_restore got %h want %h", ts_state, pre); end
    ld_valid = 1; ld_lane = 2'd1; ld_data = 32'hDEADBEEF;
    tick();
    ld_valid = 0;
    save = 1; restore = 1;
    tick();
    save = 0; restore = 0;
    checks++; if (ts_state !== pre) begin errors++; $display("FAIL sr_both got %h want %h", ts_state, pre); end
    ld_valid = 1; ld_lane = 2'd1; ld_data = 32'hCAFEF00D;
    tick();
    ld_valid = 0;
    restore = 1;
    tick();
    restore = 0;
    checks++; if (ts_state !== pre) begin errors++; $display("FAIL sr_shadow_kept got %h want %h", ts_state, pre); end
    save = 1; ld_valid = 1; ld_lane = 2'd2; ld_data = 32'h11111111;
    e = shift_in(pre, 2, 32'h11111111);
    tick();
    save = 0; ld_valid = 0;
    checks++; if (ts_state !== e) begin errors++; $display("FAIL sr_save_beat got %h want %h", ts_state, e); end
    restore = 1;
    tick();
    restore = 0;
    checks++; if (ts_state !== pre) begin errors++; $display("FAIL sr_pre_beat got %h want %h", ts_state, pre); end
    model = pre;
  endtask

  task automatic test_run_ignores;
    logic [SW-1:0] base, e;
    int n;
    mode = 0;
    ld_valid = 1; ld_lane = 2'd0; ld_data = 32'hA5A5A5A5;
    model = shift_in(model, 0, 32'hA5A5A5A5);
    tick();
    ld_valid = 0;
    base = model;
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < ROUNDS; i++) begin
      ld_valid = 1; ld_lane = 2'(i % 3); ld_data = $urandom;
      save = (i % 2 == 0); restore = (i % 3 == 1);
      #1;
      checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL ign_ready i=%0d got %b want 0", i, ld_ready); end
      exp_q.push_back(model);
      e = exp_q.pop_front();
      checks++; if (ts_state !== e) begin errors++; $display("FAIL ign_state i=%0d got %h want %h", i, ts_state, e); end
      model = ~model;
      tick();
    end
    clear_inputs();
    checks++; if (done !== 1'b1 || ts_state !== base) begin
      errors++; $display("FAIL ign_final done=%b got %h want %h", done, ts_state, base);
    end
    tick();
    restore = 1;
    tick();
    restore = 0;
    checks++; if (ts_state !== pre) begin errors++; $display("FAIL ign_shadow got %h want %h", ts_state, pre); end
    start = 1; ld_valid = 1; ld_lane = 2'd0; ld_data = 32'h77777777;
    #1;
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL start_ld_ready got %b want 0", ld_ready); end
    tick();
    clear_inputs();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_ld_busy got %b want 1", busy); end
    checks++; if (ts_state !== pre) begin errors++; $display("FAIL start_ld_state got %h want %h", ts_state, pre); end
    n = 0;
    while (done !== 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (n >= 100) begin errors++; $display("FAIL start_ld_timeout got %0d cycles want <100", n); end
    tick();
  endtask

  task automatic test_mid_reset;
    int n;
    mode = 1;
    start = 1;
    tick();
    start = 0;
    n = 0;
    while (round !== 6'd20 && n < 100) begin tick(); n++; end
    checks++; if (round !== 6'd20) begin errors++; $display("FAIL mr_reach20 got %0d want 20", round); end
    rst = 1;
    tick();
    rst = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mr_done got %b want 0", done); end
    checks++; if (round !== 6'd0) begin errors++; $display("FAIL mr_round got %0d want 0", round); end
    checks++; if (ts_state !== '0) begin errors++; $display("FAIL mr_state got %h want 0", ts_state); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL mr_idle_ready got %b want 1", ld_ready); end
    ld_valid = 1; ld_lane = 2'd3; ld_data = 32'hFFFFFFFF;
    #1;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL lane3_ready got %b want 1", ld_ready); end
    tick();
    ld_valid = 0;
    checks++; if (ts_state !== '0) begin errors++; $display("FAIL lane3_state got %h want 0", ts_state); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_load();
    test_run();
    test_enable_stall();
    test_save_restore();
    test_run_ignores();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
